dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port 64-bit data SRAM between two requesters:
  - the pipeline memory path, which issues its address, write data and byte enables one stage early;
  - a secondary requester (aux: debug/DMA) with a req/gnt handshake.
- The pipeline has priority by default. A starvation counter guarantees aux forward progress.
- Returns read data to the owner of each access and holds the last pipeline read word across stalls.

Parameters:
- STARVE_LIMIT, 8: consecutive denied aux cycles after which aux wins over the pipeline. Range 1..255.
- CNT_W, 8: width of the starvation counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pipe_en  in  1  pipeline access request this cycle
- pipe_addr  in  64  pipeline byte address
- pipe_wea  in  8  pipeline byte write enables; 0 = read
- pipe_din  in  64  pipeline write data, already lane-aligned
- pipe_ready  out  1  pipeline access accepted this cycle; low = hold request, stall
- pipe_rdata  out  64  read data for the pipeline's last accepted read
- aux_req  in  1  aux access request; held until aux_gnt
- aux_addr  in  64  aux byte address
- aux_wea  in  8  aux byte enables; 0 = read
- aux_din  in  64  aux write data
- aux_gnt  out  1  aux access accepted this cycle
- aux_rvalid  out  1  aux_rdata valid; one-cycle pulse
- aux_rdata  out  64  aux read data
- sram_addra  out  64  SRAM address
- sram_dina  out  64  SRAM write data
- sram_ena  out  1  SRAM enable
- sram_wea  out  8  SRAM byte write enables
- sram_douta  in  64  SRAM read data, valid the cycle after an enabled read

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset state:
  - starve_cnt = 0
  - rd_owner = NONE
  - pipe_rdata_q = 0
  - aux_rvalid = 0
- Combinational grant:
  - starve = (starve_cnt >= STARVE_LIMIT).
  - aux_gnt = aux_req & (~pipe_en | starve).
  - pipe_ready = ~(pipe_en & aux_gnt). pipe_ready is 1 when pipe_en = 0.
  - Consequence: during reset pipe_ready = 1 and aux_gnt follows its inputs. Requesters must not assert during reset.
- SRAM mux:
  - If aux_gnt: drive sram_* from aux.
  - Else if pipe_en: drive sram_* from pipe.
  - Else: sram_ena = 0 and sram_wea = 0; address and data are don't-care (drive pipe values).
  - sram_ena = pipe_en | aux_gnt.
- Starvation counter, updated every cycle:
  - If ~aux_req or aux_gnt: clear to 0.
  - Else: increment, saturating at 2^CNT_W-1.
  - Once starve = 1, the next aux_req cycle is granted; a held aux_req therefore waits at most STARVE_LIMIT denied cycles.
  - A starved grant costs the pipeline exactly one stall cycle per aux access.
- Read ownership register rd_owner, next value:
  - AUX if aux_gnt and aux_wea == 0;
  - else PIPE if pipe_en & pipe_ready and pipe_wea == 0;
  - else NONE.
  - Writes never create an owner.
- Read return:
  - aux_rvalid (registered) = 1 for the cycle after an aux read grant. aux_rdata = sram_douta, valid only while aux_rvalid = 1.
  - pipe_rdata = sram_douta when rd_owner == PIPE, else pipe_rdata_q.
  - pipe_rdata_q captures sram_douta at each clock edge where rd_owner == PIPE. The pipeline thus keeps its last read word even if aux uses the SRAM immediately afterwards.
- Latency:
  - Accept to data is 1 cycle for both requesters.
  - Back-to-back accesses from either side are allowed every cycle; there are no bubbles.
- Simultaneous events:
  - pipe_en & aux_req with starve = 0: pipe wins and the counter increments.
  - With starve = 1: aux wins, pipe_ready = 0, and the counter clears.
- Reset mid-operation:
  - Any in-flight read is dropped; aux_rvalid is 0 the next cycle.
  - pipe_rdata_q returns to 0.
  - No SRAM write is suppressed or replayed. The write granted in the reset cycle is still driven combinationally; requesters must not assert during reset.
- Same-cycle read/write address conflict is impossible, because only one access is issued per cycle. No forwarding is done.

Test Plan:
- Reset, then pipe read of addr 0x80 with SRAM returning 0xDEAD_BEEF_0000_1111 -> sram_ena = 1 with pipe_ready = 1 in cycle N; pipe_rdata = 0xDEAD_BEEF_0000_1111 in N+1 and held afterwards. aux_rvalid stays 0.
- aux_req alone, write of 0x1234 to 0x100 with aux_wea = 0x0F -> aux_gnt = 1 the same cycle; sram_wea = 0x0F, sram_addra = 0x100; no aux_rvalid.
- STARVE_LIMIT = 4, pipe_en held high, aux read held -> aux_gnt = 0 for 4 cycles, then aux_gnt = 1 with pipe_ready = 0 in cycle 5. aux_rvalid pulses in cycle 6; starve_cnt returns to 0.
- Pipe read in cycle N, then forced aux read in N+1 with a different douta -> pipe_rdata still shows the cycle-N+1 word (the pipe's data) in N+2. aux_rdata shows the new word in N+2.
- Assert rst in the cycle after an aux read grant -> aux_rvalid = 0, pipe_rdata = 0, and starve_cnt = 0 the following cycle. The first request after reset is granted normally.
- Alternating pipe and aux requests every cycle for 100 random cycles with a scoreboard model -> every accepted read returns correct data to its owner only. Every aux request is granted within STARVE_LIMIT+1 cycles.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bus of the data-SRAM arbiter: pipeline port plus aux req/gnt port.
// The master modport is the requester view; the slave modport is the arbiter view.
interface dmem_port_arbiter_if;
    localparam int unsigned DW  = 64;
    localparam int unsigned BEW = 8;

    logic           pipe_en;
    logic [DW-1:0]  pipe_addr;
    logic [BEW-1:0] pipe_wea;
    logic [DW-1:0]  pipe_din;
    logic           pipe_ready;
    logic [DW-1:0]  pipe_rdata;

    logic           aux_req;
    logic [DW-1:0]  aux_addr;
    logic [BEW-1:0] aux_wea;
    logic [DW-1:0]  aux_din;
    logic           aux_gnt;
    logic           aux_rvalid;
    logic [DW-1:0]  aux_rdata;

    modport master (
        output pipe_en, pipe_addr, pipe_wea, pipe_din,
        input  pipe_ready, pipe_rdata,
        output aux_req, aux_addr, aux_wea, aux_din,
        input  aux_gnt, aux_rvalid, aux_rdata
    );

    modport slave (
        input  pipe_en, pipe_addr, pipe_wea, pipe_din,
        output pipe_ready, pipe_rdata,
        input  aux_req, aux_addr, aux_wea, aux_din,
        output aux_gnt, aux_rvalid, aux_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port 64-bit data SRAM between the pipeline (default priority)
// and an aux requester, with a starvation counter guaranteeing aux progress.
module dmem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    dmem_port_arbiter_if.slave  bus,
    output logic [63:0]         o_sram_addra,
    output logic [63:0]         o_sram_dina,
    output logic                o_sram_ena,
    output logic [7:0]          o_sram_wea,
    input  logic [63:0]         i_sram_douta
);
    localparam int unsigned DW  = 64;
    localparam int unsigned BEW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_cnt_nxt;
    owner_e           r_rd_owner;
    owner_e           w_rd_owner_nxt;
    logic [DW-1:0]    r_pipe_rdata_q;
    logic             w_starve;
    logic             w_aux_gnt;
    logic             w_pipe_ready;

    assign w_starve = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));

    // Grant, SRAM mux, starvation counter and read-owner next state.
    always_comb begin
        w_aux_gnt        = bus.aux_req & (~bus.pipe_en | w_starve);
        w_pipe_ready     = ~(bus.pipe_en & w_aux_gnt);
        o_sram_addra     = bus.pipe_addr;
        o_sram_dina      = bus.pipe_din;
        o_sram_wea       = BEW'(0);
        o_sram_ena       = bus.pipe_en | w_aux_gnt;
        w_starve_cnt_nxt = r_starve_cnt;
        w_rd_owner_nxt   = OWN_NONE;

        if (w_aux_gnt) begin
            o_sram_addra = bus.aux_addr;
            o_sram_dina  = bus.aux_din;
            o_sram_wea   = bus.aux_wea;
        end else if (bus.pipe_en) begin
            o_sram_wea   = bus.pipe_wea;
        end

        if (!bus.aux_req || w_aux_gnt) begin
            w_starve_cnt_nxt = CNT_W'(0);
        end else if (r_starve_cnt != {CNT_W{1'b1}}) begin
            w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
        end

        if (w_aux_gnt && (bus.aux_wea == BEW'(0))) begin
            w_rd_owner_nxt = OWN_AUX;
        end else if (bus.pipe_en && w_pipe_ready && (bus.pipe_wea == BEW'(0))) begin
            w_rd_owner_nxt = OWN_PIPE;
        end
    end

    // State registers; the pipeline's last read word is kept across aux use of the SRAM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt   <= CNT_W'(0);
            r_rd_owner     <= OWN_NONE;
            r_pipe_rdata_q <= DW'(0);
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_rd_owner   <= w_rd_owner_nxt;
            if (r_rd_owner == OWN_PIPE) begin
                r_pipe_rdata_q <= i_sram_douta;
            end
        end
    end

    assign bus.aux_gnt    = w_aux_gnt;
    assign bus.pipe_ready = w_pipe_ready;
    assign bus.aux_rvalid = (r_rd_owner == OWN_AUX);
    assign bus.aux_rdata  = i_sram_douta;
    assign bus.pipe_rdata = (r_rd_owner == OWN_PIPE) ? i_sram_douta : r_pipe_rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios, then randomized traffic against
// a transaction-level model of ownership, grant fairness and memory contents.
module tb_dmem_port_arbiter;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned WORDS = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_load = 1'b1;
    logic [63:0] sram_addra;
    logic [63:0] sram_dina;
    logic        sram_ena;
    logic [7:0]  sram_wea;
    logic [63:0] sram_douta = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .o_sram_addra (sram_addra),
        .o_sram_dina  (sram_dina),
        .o_sram_ena   (sram_ena),
        .o_sram_wea   (sram_wea),
        .i_sram_douta (sram_douta)
    );

    function automatic logic [63:0] word_init(int i);
        if (i == 16) return 64'hDEAD_BEEF_0000_1111;
        if (i == 32) return 64'h0;
        return {32'(i) ^ 32'hA5A5_0000, 32'(i) * 32'h9E37_79B9};
    endfunction

    // SRAM behavioural model: registered read, byte-lane writes.
    logic [63:0] mem [WORDS];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < int'(WORDS); i++) mem[i] = word_init(i);
        end else if (sram_ena) begin
            if (sram_wea == 8'h00) begin
                sram_douta <= mem[sram_addra[9:3]];
            end else begin
                for (int b = 0; b < 8; b++)
                    if (sram_wea[b]) mem[sram_addra[9:3]][b*8 +: 8] = sram_dina[b*8 +: 8];
            end
        end
    end

    logic [63:0] ref_mem [WORDS];

    task automatic ref_write(input int idx, input logic [7:0] be, input logic [63:0] d);
        for (int b = 0; b < 8; b++)
            if (be[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_en   = 1'b0;
        bus.pipe_addr = '0;
        bus.pipe_wea  = '0;
        bus.pipe_din  = '0;
        bus.aux_req   = 1'b0;
        bus.aux_addr  = '0;
        bus.aux_wea   = '0;
        bus.aux_din   = '0;
    endtask

    initial begin
        int          prev_kind;   // 0 none, 1 pipe read, 2 aux read
        logic [63:0] prev_data;
        logic [63:0] last_pipe;
        int          waited;
        int          obs_wait;
        logic        pipe_hold;
        logic        aux_hold;
        logic        exp_gnt;
        logic        exp_ready;
        int          idx;

        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = word_init(i);
        idle();
        repeat (2) tick();
        mem_load = 1'b0;
        rst      = 1'b0;
        #1;
        check("rst_pipe_ready", 64'(bus.pipe_ready), 64'd1);
        check("rst_aux_gnt",    64'(bus.aux_gnt),    64'd0);
        check("rst_sram_ena",   64'(sram_ena),       64'd0);
        check("rst_aux_rvalid", 64'(bus.aux_rvalid), 64'd0);
        check("rst_pipe_rdata", bus.pipe_rdata,      64'd0);

        // Pipeline read of 0x80
        bus.pipe_en = 1'b1; bus.pipe_addr = 64'h80; bus.pipe_wea = 8'h00;
        #1;
        check("p_rd_ena",   64'(sram_ena),       64'd1);
        check("p_rd_ready", 64'(bus.pipe_ready), 64'd1);
        check("p_rd_addr",  sram_addra,          64'h80);
        tick(); idle(); #1;
        check("p_rd_data",   bus.pipe_rdata,      64'hDEAD_BEEF_0000_1111);
        check("p_rd_rvalid", 64'(bus.aux_rvalid), 64'd0);
        tick(); #1;
        check("p_rd_hold",   bus.pipe_rdata,      64'hDEAD_BEEF_0000_1111);

        // Aux write alone
        bus.aux_req = 1'b1; bus.aux_addr = 64'h100; bus.aux_wea = 8'h0F; bus.aux_din = 64'h1234;
        #1;
        check("a_wr_gnt",   64'(bus.aux_gnt),    64'd1);
        check("a_wr_wea",   64'(sram_wea),       64'h0F);
        check("a_wr_addr",  sram_addra,          64'h100);
        check("a_wr_din",   sram_dina,           64'h1234);
        check("a_wr_ready", 64'(bus.pipe_ready), 64'd1);
        ref_write(32, 8'h0F, 64'h1234);
        tick(); idle(); #1;
        check("a_wr_no_rvalid", 64'(bus.aux_rvalid), 64'd0);

        // Starvation: pipe held busy, aux read held
        bus.pipe_en = 1'b1; bus.pipe_addr = 64'h80; bus.pipe_wea = 8'h00;
        bus.aux_req = 1'b1; bus.aux_addr  = 64'h100; bus.aux_wea = 8'h00;
        for (int k = 0; k < int'(LIMIT); k++) begin
            #1;
            check("stv_denied", 64'(bus.aux_gnt),    64'd0);
            check("stv_pready", 64'(bus.pipe_ready), 64'd1);
            tick();
        end
        #1;
        check("stv_gnt",   64'(bus.aux_gnt),    64'd1);
        check("stv_stall", 64'(bus.pipe_ready), 64'd0);
        check("stv_addr",  sram_addra,          64'h100);
        tick();
        // A fresh aux read follows immediately; the counter must have restarted
        for (int k = 0; k < int'(LIMIT); k++) begin
            #1;
            if (k == 0) begin
                check("stv_rvalid",     64'(bus.aux_rvalid), 64'd1);
                check("stv_rdata",      bus.aux_rdata,       64'h1234);
                check("stv_pipe_keep",  bus.pipe_rdata,      64'hDEAD_BEEF_0000_1111);
            end
            check("stv2_denied", 64'(bus.aux_gnt), 64'd0);
            tick();
        end
        #1;
        check("stv2_gnt", 64'(bus.aux_gnt), 64'd1);
        tick(); idle(); #1;
        // Pipe read in previous-but-one cycle, aux read last cycle
        check("own_pipe_data", bus.pipe_rdata,      64'hDEAD_BEEF_0000_1111);
        check("own_aux_data",  bus.aux_rdata,       64'h1234);
        check("own_aux_valid", 64'(bus.aux_rvalid), 64'd1);

        // Reset in the cycle after an aux read grant
        bus.aux_req = 1'b1; bus.aux_addr = 64'h80; bus.aux_wea = 8'h00;
        #1;
        check("rr_gnt", 64'(bus.aux_gnt), 64'd1);
        tick(); idle(); rst = 1'b1; #1;
        check("rr_rvalid_pre", 64'(bus.aux_rvalid), 64'd1);
        tick(); rst = 1'b0; #1;
        check("rr_rvalid", 64'(bus.aux_rvalid), 64'd0);
        check("rr_prdata", bus.pipe_rdata,      64'd0);
        bus.aux_req = 1'b1; bus.aux_addr = 64'h80; bus.aux_wea = 8'h00;
        #1;
        check("rr_first_gnt", 64'(bus.aux_gnt), 64'd1);
        tick(); idle(); #1;
        check("rr_first_data", bus.aux_rdata, 64'hDEAD_BEEF_0000_1111);
        check("rr_first_vld",  64'(bus.aux_rvalid), 64'd1);
        tick();

        // Randomized mixed traffic against the transaction model
        prev_kind = 0; prev_data = '0; last_pipe = '0;
        waited = 0; obs_wait = 0; pipe_hold = 1'b0; aux_hold = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (!pipe_hold) begin
                bus.pipe_en   = ($urandom_range(3) != 0);
                bus.pipe_addr = 64'($urandom_range(WORDS - 1)) << 3;
                bus.pipe_wea  = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
                bus.pipe_din  = {$urandom, $urandom};
            end
            if (!aux_hold) begin
                bus.aux_req  = ($urandom_range(1) == 1);
                bus.aux_addr = 64'($urandom_range(WORDS - 1)) << 3;
                bus.aux_wea  = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
                bus.aux_din  = {$urandom, $urandom};
            end
            #1;
            exp_gnt   = bus.aux_req && (!bus.pipe_en || waited >= int'(LIMIT));
            exp_ready = !(bus.pipe_en && exp_gnt);
            check("rnd_gnt",   64'(bus.aux_gnt),    64'(exp_gnt));
            check("rnd_ready", 64'(bus.pipe_ready), 64'(exp_ready));

            check("rnd_rvalid", 64'(bus.aux_rvalid), 64'(prev_kind == 2));
            if (prev_kind == 2) check("rnd_aux_rdata", bus.aux_rdata, prev_data);
            if (prev_kind == 1) last_pipe = prev_data;
            check("rnd_pipe_rdata", bus.pipe_rdata, last_pipe);

            if (bus.aux_req && !bus.aux_gnt) obs_wait++;
            else obs_wait = 0;
            check("rnd_aux_bound", 64'(obs_wait <= int'(LIMIT)), 64'd1);

            prev_kind = 0;
            if (exp_gnt) begin
                idx = int'(bus.aux_addr[9:3]);
                if (bus.aux_wea == 8'h00) begin
                    prev_kind = 2; prev_data = ref_mem[idx];
                end else begin
                    ref_write(idx, bus.aux_wea, bus.aux_din);
                end
                waited = 0;
            end else begin
                waited = bus.aux_req ? waited + 1 : 0;
            end
            if (bus.pipe_en && exp_ready) begin
                idx = int'(bus.pipe_addr[9:3]);
                if (bus.pipe_wea == 8'h00) begin
                    prev_kind = 1; prev_data = ref_mem[idx];
                end else begin
                    ref_write(idx, bus.pipe_wea, bus.pipe_din);
                end
            end
            pipe_hold = bus.pipe_en && !bus.pipe_ready;
            aux_hold  = bus.aux_req && !bus.aux_gnt;
            tick();
        end
        idle(); #1;
        check("rnd_final_rvalid", 64'(bus.aux_rvalid), 64'(prev_kind == 2));
        if (prev_kind == 2) check("rnd_final_aux", bus.aux_rdata, prev_data);
        if (prev_kind == 1) last_pipe = prev_data;
        check("rnd_final_pipe", bus.pipe_rdata, last_pipe);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
